// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS sequencer: state encoding,
// instruction field constants and datapath select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_LW_WB   = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EX    = 4'd6,
    S_R_WB    = 4'd7,
    S_BEQ     = 4'd8,
    S_JMP     = 4'd9,
    S_I_EX    = 4'd10,
    S_I_WB    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the sequencer (master) and the multicycle datapath (slave).
interface mc_ctrl_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_ld;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       inst_done;
  logic       illegal;

  modport master (
    input  opcode, funct, zero,
    output pc_ld, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, inst_done, illegal
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_ld, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, inst_done, illegal
  );
endinterface

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// ALU operation decoder shared by the execute and writeback states; also
// flags whether an R-type funct field is one the datapath supports.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       funct_valid_o
);

  always_comb begin
    alu_op_o      = ALU_ADD;
    funct_valid_o = 1'b0;
    if (opcode_i == OP_RTYPE) begin
      funct_valid_o = 1'b1;
      case (funct_i)
        FN_ADD:  alu_op_o = ALU_ADD;
        FN_SUB:  alu_op_o = ALU_SUB;
        FN_AND:  alu_op_o = ALU_AND;
        FN_OR:   alu_op_o = ALU_OR;
        FN_SLT:  alu_op_o = ALU_SLT;
        default: begin
          alu_op_o      = ALU_ADD;
          funct_valid_o = 1'b0;
        end
      endcase
    end else if (opcode_i == OP_SLTI) begin
      alu_op_o = ALU_SLT;
    end else begin
      alu_op_o = ALU_ADD;
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Moore sequencer for the multicycle MIPS datapath; memory access states are
// stretched by MEM_LAT wait cycles using a small counter.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  mc_ctrl_fsm_if.master   bus
);

  localparam int CW = (MEM_LAT == 0) ? 1 : $clog2(MEM_LAT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_last;
  logic          wait_state;
  logic [2:0]    dec_alu_op;
  logic          dec_funct_valid;

  mc_alu_dec u_alu_dec (
    .opcode_i      (bus.opcode),
    .funct_i       (bus.funct),
    .alu_op_o      (dec_alu_op),
    .funct_valid_o (dec_funct_valid)
  );

  assign cnt_last   = (cnt_q == CW'(MEM_LAT));
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter returns to zero whenever a wait state completes, so entry always sees 0.
  always_comb begin
    state_d = state_q;
    if (wait_state && !cnt_last) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
    case (state_q)
      S_FETCH:   state_d = cnt_last ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:               state_d = S_MEM_ADR;
          OP_RTYPE:                   state_d = dec_funct_valid ? S_R_EX : S_FETCH;
          OP_BEQ:                     state_d = S_BEQ;
          OP_J:                       state_d = S_JMP;
          OP_ADDI, OP_ADDIU, OP_SLTI: state_d = S_I_EX;
          default:                    state_d = S_FETCH;
        endcase
      end
      S_MEM_ADR: state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = cnt_last ? S_LW_WB : S_MEM_RD;
      S_MEM_WR:  state_d = cnt_last ? S_FETCH : S_MEM_WR;
      S_R_EX:    state_d = S_R_WB;
      S_I_EX:    state_d = S_I_WB;
      S_LW_WB, S_R_WB, S_I_WB, S_BEQ, S_JMP: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.pc_ld      = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_B;
    bus.alu_op     = ALU_ADD;
    bus.pc_src     = PCSRC_ALU;
    bus.inst_done  = 1'b0;
    bus.illegal    = 1'b0;
    if (rst) begin
      bus.pc_ld = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          bus.ir_write  = cnt_last;
          bus.pc_ld     = cnt_last;
        end
        S_DECODE: begin
          bus.alu_src_b = SRCB_IMMSH;
          // Only undecodable instructions fall straight back to fetch.
          bus.illegal   = (state_d == S_FETCH);
          bus.inst_done = (state_d == S_FETCH);
        end
        S_MEM_ADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          bus.i_or_d   = 1'b1;
          bus.mem_read = 1'b1;
        end
        S_LW_WB: begin
          bus.mem_to_reg = 1'b1;
          bus.reg_write  = 1'b1;
          bus.inst_done  = 1'b1;
        end
        S_MEM_WR: begin
          bus.i_or_d    = 1'b1;
          bus.mem_write = 1'b1;
          bus.inst_done = cnt_last;
        end
        S_R_EX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = dec_alu_op;
        end
        S_R_WB: begin
          bus.reg_dst   = 1'b1;
          bus.reg_write = 1'b1;
          bus.alu_op    = dec_alu_op;
          bus.inst_done = 1'b1;
        end
        S_BEQ: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALU_SUB;
          bus.pc_src    = PCSRC_OUT;
          bus.pc_ld     = bus.zero;
          bus.inst_done = 1'b1;
        end
        S_JMP: begin
          bus.pc_src    = PCSRC_JUMP;
          bus.pc_ld     = 1'b1;
          bus.inst_done = 1'b1;
        end
        S_I_EX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          bus.alu_op    = dec_alu_op;
        end
        S_I_WB: begin
          bus.reg_write = 1'b1;
          bus.alu_op    = dec_alu_op;
          bus.inst_done = 1'b1;
        end
        default: bus.pc_ld = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Moore-style multicycle sequencer for the MIPS multicycle datapath. It sits between the instruction register's opcode/funct fields and the datapath muxes, the unified byte-addressed memory and the write enables. It steps each instruction through fetch, decode, execute, memory and writeback. A fixed memory latency is absorbed by a wait counter.

Parameters:
MEM_LAT, 0, extra wait cycles per memory access (each access state lasts MEM_LAT+1 cycles)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
pc_ld  out  1  PC load enable
i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
reg_dst  out  1  register write address: 0 = rt, 1 = rd
mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A operand: 0 = PC, 1 = A register
alu_src_b  out  2  ALU B operand: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
alu_op  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
pc_src  out  2  next PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
inst_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  one-cycle pulse on an undecodable instruction

Behaviour:
- Reset: rst sampled high moves the state to FETCH and clears the wait counter. While rst is high, all outputs are forced to 0 combinationally. A reset in any state, including mid-wait, aborts the instruction with no further strobes.
- Any output not listed for a state is 0.
- States and outputs:
  - FETCH: i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00. ir_write and pc_ld are 1 only on the last wait cycle. Then go to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes branch target). Next state by opcode:
    - 100011 lw / 101011 sw -> MEM_ADR
    - 000000 R-type -> R_EX
    - 000100 beq -> BEQ
    - 000010 j -> JMP
    - 001000/001001 addi, 001010 slti -> I_EX
    - anything else -> FETCH with illegal=1 and inst_done=1
  - R-type with funct outside {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt} is treated as illegal.
  - MEM_ADR: alu_src_a=1, alu_src_b=10, ADD. Go to MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: i_or_d=1, mem_read=1 held for all wait cycles. Go to LW_WB.
  - LW_WB: reg_dst=0, mem_to_reg=1, reg_write=1, inst_done=1. Go to FETCH.
  - MEM_WR: i_or_d=1, mem_write=1 held for all wait cycles. inst_done=1 on the last cycle. Go to FETCH.
  - R_EX: alu_src_a=1, alu_src_b=00, alu_op from funct. Go to R_WB.
  - R_WB: reg_dst=1, reg_write=1, alu_op held, inst_done=1. Go to FETCH.
  - BEQ: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_ld=zero (the only Mealy term), inst_done=1. Go to FETCH.
  - JMP: pc_src=10, pc_ld=1, inst_done=1. Go to FETCH.
  - I_EX: alu_src_a=1, alu_src_b=10, alu_op ADD (addi) or SLT (slti). Go to I_WB.
  - I_WB: reg_dst=0, reg_write=1, alu_op held, inst_done=1. Go to FETCH.
- Wait counter:
  - Used only in FETCH, MEM_RD and MEM_WR. Cleared on entry to those states.
  - Counts 0..MEM_LAT; the state advances when the count equals MEM_LAT.
  - Width is max(1, clog2(MEM_LAT+1)).
  - With MEM_LAT=0 every state lasts exactly 1 cycle.
- Cycle counts at MEM_LAT=0: lw 5, sw 4, R 4, I 4, beq 3, j 3, illegal 2. Each memory-access state adds MEM_LAT cycles.
- pc_ld and ir_write are never asserted in the same cycle as mem_write. reg_write is never asserted together with mem_read.

Decomposition:
- Shared package mc_pkg holds:
  - state encoding (4-bit enum)
  - opcode and funct constants
  - ALU_ADD/SUB/AND/OR/SLT codes
  - ALU B select and PC source select codes
- One combinational sub-module, mc_alu_dec, maps (opcode, funct) to alu_op plus a funct_valid flag. It is reused by the EX and WB states.

Test Plan:
- Reset: rst=1 for 2 cycles from an arbitrary state -> all outputs 0. First cycle after release: mem_read=1, i_or_d=0, alu_src_b=01; then ir_write=1 and pc_ld=1 in that same cycle.
- lw (opcode 100011), MEM_LAT=0 -> state sequence FETCH, DECODE, MEM_ADR, MEM_RD, LW_WB. reg_write=1 with mem_to_reg=1 and reg_dst=0 on cycle 5; inst_done pulses once.
- R-type slt (funct 101010) -> alu_op=100 in R_EX and R_WB, reg_dst=1, 4 cycles total. Repeat with funct 111111 -> illegal=1 in DECODE, back in FETCH on cycle 3.
- beq (000100) with zero=1 -> pc_ld=1 and pc_src=01 in cycle 3. With zero=0 -> pc_ld=0, and the next FETCH starts on cycle 4.
- MEM_LAT=2, sw (101011) -> FETCH lasts 3 cycles with ir_write only on the 3rd. MEM_WR asserts mem_write for exactly 3 cycles; 8 cycles total.
- rst asserted on the 2nd wait cycle of MEM_RD (MEM_LAT=2) -> the following cycle has no reg_write, and FETCH restarts with the wait counter at 0.
